// File: rtl/hifp_result_packer.sv
// Packs 32-bit per-work-item results into 512-bit lines keyed by global id and
// writes completed or flushed lines through an Avalon-MM write master.
module hifp_result_packer #(
    parameter int MAX_PENDING = 8,
    parameter int PENDING_W   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         m_valid_in,
    output logic         m_ready_out,
    input  logic [31:0]  m_input_0,
    input  logic [31:0]  m_input_global_id_0,
    input  logic [31:0]  m_input_base_addr,
    input  logic         m_flush,
    output logic         m_idle,
    output logic [31:0]  avm_out_address,
    output logic         avm_out_write,
    output logic [511:0] avm_out_writedata,
    output logic [63:0]  avm_out_byteenable,
    output logic [4:0]   avm_out_burstcount,
    input  logic         avm_out_waitrequest,
    input  logic         avm_out_writeack
);
    logic [511:0]         fill_data_q, fill_data_d;
    logic [15:0]          fill_be_q, fill_be_d;
    logic [27:0]          fill_line_q, fill_line_d;
    logic                 flush_pending_q, flush_pending_d;
    logic [511:0]         out_data_q, out_data_d;
    logic [63:0]          out_be_q, out_be_d;
    logic [31:0]          out_addr_q, out_addr_d;
    logic                 out_busy_q, out_busy_d;
    logic [PENDING_W-1:0] pending_q, pending_d;

    logic [3:0]   slot;
    logic [27:0]  line;
    logic         accept, wr_done, ack_ok, flush_req, evict, load_out;
    logic [511:0] cand_data, ld_data;
    logic [15:0]  cand_be, ld_be;
    logic [27:0]  cand_line, ld_line;

    assign slot = m_input_global_id_0[3:0];
    assign line = m_input_global_id_0[31:4];

    assign m_ready_out        = !out_busy_q && !reset;
    assign avm_out_write      = out_busy_q && (pending_q < PENDING_W'(MAX_PENDING)) && !reset;
    assign m_idle             = (fill_be_q == '0) && !out_busy_q && (pending_q == '0) && !flush_pending_q;
    assign avm_out_address    = out_addr_q;
    assign avm_out_writedata  = out_data_q;
    assign avm_out_byteenable = out_be_q;
    assign avm_out_burstcount = 5'd1;

    assign accept    = m_valid_in && m_ready_out;
    assign wr_done   = avm_out_write && !avm_out_waitrequest;
    assign ack_ok    = avm_out_writeack && (pending_q != '0);
    assign flush_req = flush_pending_q || m_flush;
    assign evict     = accept && (fill_be_q != '0) && (line != fill_line_q);

    always_comb begin
        // Fill buffer as it would look with the accepted word merged in.
        cand_data = fill_data_q;
        cand_be   = fill_be_q;
        cand_line = fill_line_q;
        if (accept && !evict) begin
            cand_data[{slot, 5'b0} +: 32] = m_input_0;
            cand_be[slot]                 = 1'b1;
            cand_line                     = line;
        end

        fill_data_d     = cand_data;
        fill_be_d       = cand_be;
        fill_line_d     = cand_line;
        flush_pending_d = flush_req;
        load_out        = 1'b0;
        ld_data         = fill_data_q;
        ld_be           = fill_be_q;
        ld_line         = fill_line_q;

        if (evict) begin
            // Old line leaves; a pending flush now applies to the new line.
            load_out                        = 1'b1;
            fill_data_d                     = '0;
            fill_data_d[{slot, 5'b0} +: 32] = m_input_0;
            fill_be_d                       = 16'd1 << slot;
            fill_line_d                     = line;
        end else if ((cand_be == '1) || (flush_req && (cand_be != '0) && !out_busy_q)) begin
            load_out        = 1'b1;
            ld_data         = cand_data;
            ld_be           = cand_be;
            ld_line         = cand_line;
            fill_data_d     = '0;
            fill_be_d       = '0;
            flush_pending_d = 1'b0;
        end else if (cand_be == '0) begin
            flush_pending_d = 1'b0;
        end

        out_data_d = out_data_q;
        out_be_d   = out_be_q;
        out_addr_d = out_addr_q;
        out_busy_d = out_busy_q && !wr_done;
        if (load_out) begin
            out_data_d = ld_data;
            for (int i = 0; i < 16; i++) out_be_d[4*i +: 4] = {4{ld_be[i]}};
            out_addr_d = m_input_base_addr + 32'({ld_line, 6'b0});
            out_busy_d = 1'b1;
        end

        pending_d = pending_q;
        if (wr_done && !ack_ok)      pending_d = pending_q + PENDING_W'(1);
        else if (!wr_done && ack_ok) pending_d = pending_q - PENDING_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_data_q     <= '0;
            fill_be_q       <= '0;
            fill_line_q     <= '0;
            flush_pending_q <= 1'b0;
            out_data_q      <= '0;
            out_be_q        <= '0;
            out_addr_q      <= '0;
            out_busy_q      <= 1'b0;
            pending_q       <= '0;
        end else begin
            fill_data_q     <= fill_data_d;
            fill_be_q       <= fill_be_d;
            fill_line_q     <= fill_line_d;
            flush_pending_q <= flush_pending_d;
            out_data_q      <= out_data_d;
            out_be_q        <= out_be_d;
            out_addr_q      <= out_addr_d;
            out_busy_q      <= out_busy_d;
            pending_q       <= pending_d;
        end
    end
endmodule
